// File: rtl/dpram_fifo_ctrl.sv
// Valid/ready FIFO built around an external dual-port RAM; empty-FIFO latency is accept edge + 2 to m_valid.
// Sustains 1 word/cycle; s_ready drops only when the RAM holds DEPTH words (2-entry output buffer hides read latency).
module dpram_fifo_ctrl #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  ram_we_a,
   output logic [ADDR_WIDTH-1:0] ram_addr_a,
   output logic [DATA_WIDTH-1:0] ram_data_a,
   output logic                  ram_re_b,
   output logic [ADDR_WIDTH-1:0] ram_addr_b,
   input  logic [DATA_WIDTH-1:0] ram_data_b,
   output logic [ADDR_WIDTH+1:0] count
);

   localparam logic [ADDR_WIDTH:0]   DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   ram_cnt;
   logic                  inflight;
   logic [DATA_WIDTH-1:0] obuf [0:1];
   logic [1:0]            ob_cnt;
   logic                  run;

   logic                  push;
   logic                  pop;
   logic                  issue;
   logic [2:0]            ob_demand;
   logic [2:0]            ob_limit;
   logic [ADDR_WIDTH:0]   ram_cnt_nxt;
   logic [1:0]            ob_cnt_nxt;
   logic [DATA_WIDTH-1:0] obuf0_nxt;
   logic [DATA_WIDTH-1:0] obuf1_nxt;
   logic                  land_slot1;

   // run keeps s_ready low while reset is held and until the first edge after release
   assign s_ready = run && !flush && (ram_cnt < DEPTH_C);
   assign push    = s_valid && s_ready;
   assign m_valid = (ob_cnt != 2'd0);
   assign m_data  = obuf[0];
   assign pop     = m_valid && m_ready;

   // a read may only be issued if its word is guaranteed a buffer slot when it lands
   assign ob_demand = {1'b0, ob_cnt} + {2'b00, inflight};
   assign ob_limit  = 3'd1 + {2'b00, pop};
   assign issue     = (ram_cnt != '0) && !flush && (ob_demand <= ob_limit);

   assign ram_we_a   = push;
   assign ram_addr_a = wr_ptr;
   assign ram_data_a = s_data;
   assign ram_re_b   = issue;
   assign ram_addr_b = rd_ptr;

   assign ram_cnt_nxt = ram_cnt + {{ADDR_WIDTH{1'b0}}, push} - {{ADDR_WIDTH{1'b0}}, issue};
   assign ob_cnt_nxt  = ob_cnt + {1'b0, inflight} - {1'b0, pop};

   assign count = {1'b0, ram_cnt}
                + {{(ADDR_WIDTH+1){1'b0}}, inflight}
                + {{ADDR_WIDTH{1'b0}}, ob_cnt};

   // head lives in obuf[0]; a landing word goes behind whatever survives this cycle's pop
   always_comb begin
      obuf0_nxt  = obuf[0];
      obuf1_nxt  = obuf[1];
      land_slot1 = (ob_cnt == 2'd2) || ((ob_cnt == 2'd1) && !pop);
      if (pop) begin
         obuf0_nxt = obuf[1];
      end
      if (inflight) begin
         if (land_slot1) begin
            obuf1_nxt = ram_data_b;
         end else begin
            obuf0_nxt = ram_data_b;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         ram_cnt  <= '0;
         inflight <= 1'b0;
         ob_cnt   <= 2'd0;
         obuf[0]  <= '0;
         obuf[1]  <= '0;
         run      <= 1'b0;
      end else begin
         run <= 1'b1;
         if (flush) begin
            // the outstanding read is dropped: inflight clears so its data never lands
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
            ob_cnt   <= 2'd0;
         end else begin
            if (push) begin
               wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (issue) begin
               rd_ptr <= rd_ptr + PTR_ONE;
            end
            ram_cnt  <= ram_cnt_nxt;
            inflight <= issue;
            ob_cnt   <= ob_cnt_nxt;
            obuf[0]  <= obuf0_nxt;
            obuf[1]  <= obuf1_nxt;
         end
      end
   end

   assert property (@(posedge clk) disable iff (!rst_n)
      !(inflight && !pop && !flush && (ob_cnt == 2'd2)));

endmodule
